// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel word receiver with a one-word valid/ready output buffer.
// Build option PARITY_EN appends a trailing even-parity bit to every word.
module serial_word_receiver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_din,
  input  logic             s_first,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             ovr_err,
  output logic             sync_err,
  output logic             par_err,
  input  logic             clr_status
);

  // state  | meaning
  // IDLE   | waiting for a bit qualified by s_first
  // SHIFT  | collecting the data bits of a word
  // PARITY | waiting for the trailing parity bit (PARITY_EN builds only)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_next, sh_first;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             order_q, order_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             pvalid_q, pvalid_d;
  logic             ovr_q, ovr_d, ovr_set;
  logic             sync_q, sync_d, sync_set;
  logic             done;
  logic [WIDTH-1:0] done_word;
`ifdef PARITY_EN
  logic             par_q, par_d, par_set;
`endif

  assign sh_next  = order_q   ? {s_din, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], s_din};
  assign sh_first = lsb_first ? {s_din, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, s_din};

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    order_d   = order_q;
    done      = 1'b0;
    done_word = sh_next;
    sync_set  = 1'b0;
`ifdef PARITY_EN
    par_set   = 1'b0;
`endif
    if (s_valid) begin
      // s_first always starts a fresh word; mid-word it also aborts the partial one
      if (s_first) begin
        sync_set = (state_q != ST_IDLE);
        state_d  = ST_SHIFT;
        sh_d     = sh_first;
        cnt_d    = CNT_W'(1);
        order_d  = lsb_first;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_IDLE;
              cnt_d   = '0;
              done    = 1'b1;
`endif
            end
          end
`ifdef PARITY_EN
          ST_PARITY: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            done_word = sh_q;
            if (^{sh_q, s_din}) par_set = 1'b1;
            else                done    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dout_d   = dout_q;
    pvalid_d = pvalid_q;
    ovr_set  = 1'b0;
    if (done) begin
      if (!pvalid_q || p_ready) begin
        dout_d   = done_word;
        pvalid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (pvalid_q && p_ready) begin
      pvalid_d = 1'b0;
    end
    ovr_d  = ovr_set  | (ovr_q  & ~clr_status);
    sync_d = sync_set | (sync_q & ~clr_status);
`ifdef PARITY_EN
    par_d  = par_set  | (par_q  & ~clr_status);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      order_q  <= 1'b0;
      dout_q   <= '0;
      pvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      sync_q   <= 1'b0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      order_q  <= order_d;
      dout_q   <= dout_d;
      pvalid_q <= pvalid_d;
      ovr_q    <= ovr_d;
      sync_q   <= sync_d;
`ifdef PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign p_dout   = dout_q;
  assign p_valid  = pvalid_q;
  assign busy     = (state_q != ST_IDLE);
  assign ovr_err  = ovr_q;
  assign sync_err = sync_q;
`ifdef PARITY_EN
  assign par_err  = par_q;
`else
  assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4): cycle-by-cycle vector table
// plus hand-written sequences for back-to-back accept, long stalls and parity.
module tb_serial_word_receiver;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, s_valid, s_din, s_first, lsb_first, p_ready, clr_status;
  logic [W-1:0] p_dout;
  logic         p_valid, busy, ovr_err, sync_err, par_err;
  int           n_vec = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_din(s_din), .s_first(s_first),
    .lsb_first(lsb_first), .p_dout(p_dout), .p_valid(p_valid), .p_ready(p_ready),
    .busy(busy), .ovr_err(ovr_err), .sync_err(sync_err), .par_err(par_err),
    .clr_status(clr_status)
  );

  typedef struct {
    logic rstn, sv, din, sf, lsb, rdy, clr;
    logic pv; logic [3:0] dout; logic bsy, ovr, syn;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic rstn, sv, din, sf, lsb, rdy, clr,
                              input logic pv, input logic [3:0] dout, input logic bsy, ovr, syn);
    vec_t v;
    v.rstn = rstn; v.sv = sv; v.din = din; v.sf = sf; v.lsb = lsb; v.rdy = rdy; v.clr = clr;
    v.pv = pv; v.dout = dout; v.bsy = bsy; v.ovr = ovr; v.syn = syn;
    vq.push_back(v);
  endfunction

  task automatic step(input logic rstn, sv, din, sf, lsb, rdy, clr);
    @(negedge clk);
    rst_n = rstn; s_valid = sv; s_din = din; s_first = sf;
    lsb_first = lsb; p_ready = rdy; clr_status = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic pv, input logic [3:0] dout,
                       input logic bsy, ovr, syn, par);
    logic [8:0] act, exp;
    act = {p_valid, p_dout, busy, ovr_err, sync_err, par_err};
    exp = {pv, dout, bsy, ovr, syn, par};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pv=%b dout=%h busy=%b ovr=%b sync=%b par=%b, want pv=%b dout=%h busy=%b ovr=%b sync=%b par=%b",
               tag, p_valid, p_dout, busy, ovr_err, sync_err, par_err, pv, dout, bsy, ovr, syn, par);
    end
  endtask

  task automatic send_word(input logic [3:0] w, input logic lsb, input logic rdy_rest, input logic rdy_last);
    for (int i = 0; i < W; i++)
      step(1'b1, 1'b1, lsb ? w[i] : w[W-1-i], (i == 0), lsb, (i == W-1) ? rdy_last : rdy_rest, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_din = 1'b0; s_first = 1'b0;
    lsb_first = 1'b0; p_ready = 1'b0; clr_status = 1'b0;

`ifndef PARITY_EN
    // rstn sv din sf lsb rdy clr | pv dout busy ovr sync
    add(0,0,0,0,0,0,0, 0,4'h0,0,0,0);
    add(0,1,1,1,0,1,0, 0,4'h0,0,0,0);
    // MSB-first 1,0,1,1 -> B
    add(1,1,1,1,0,1,0, 0,4'h0,1,0,0);
    add(1,1,0,0,0,1,0, 0,4'h0,1,0,0);
    add(1,1,1,0,0,1,0, 0,4'h0,1,0,0);
    add(1,1,1,0,0,1,0, 1,4'hB,0,0,0);
    add(1,0,0,0,0,1,0, 0,4'hB,0,0,0);
    // LSB-first 1,0,1,1 with 3-cycle gaps -> D; lsb_first dropped after first bit
    add(1,1,1,1,1,1,0, 0,4'hB,1,0,0);
    for (int k = 0; k < 3; k++) add(1,0,0,0,0,1,0, 0,4'hB,1,0,0);
    add(1,1,0,0,0,1,0, 0,4'hB,1,0,0);
    for (int k = 0; k < 3; k++) add(1,0,0,0,0,1,0, 0,4'hB,1,0,0);
    add(1,1,1,0,0,1,0, 0,4'hB,1,0,0);
    for (int k = 0; k < 3; k++) add(1,0,1,0,0,1,0, 0,4'hB,1,0,0);
    add(1,1,1,0,0,1,0, 1,4'hD,0,0,0);
    add(1,0,0,0,0,1,0, 0,4'hD,0,0,0);
    // p_ready low: A delivered, 5 overruns
    add(1,1,1,1,0,0,0, 0,4'hD,1,0,0);
    add(1,1,0,0,0,0,0, 0,4'hD,1,0,0);
    add(1,1,1,0,0,0,0, 0,4'hD,1,0,0);
    add(1,1,0,0,0,0,0, 1,4'hA,0,0,0);
    add(1,1,0,1,0,0,0, 1,4'hA,1,0,0);
    add(1,1,1,0,0,0,0, 1,4'hA,1,0,0);
    add(1,1,0,0,0,0,0, 1,4'hA,1,0,0);
    add(1,1,1,0,0,0,0, 1,4'hA,0,1,0);
    add(1,0,0,0,0,0,1, 1,4'hA,0,0,0);
    // F overruns again, then 3 overruns together with clr_status: set wins
    add(1,1,1,1,0,0,0, 1,4'hA,1,0,0);
    add(1,1,1,0,0,0,0, 1,4'hA,1,0,0);
    add(1,1,1,0,0,0,0, 1,4'hA,1,0,0);
    add(1,1,1,0,0,0,0, 1,4'hA,0,1,0);
    add(1,1,0,1,0,0,0, 1,4'hA,1,1,0);
    add(1,1,0,0,0,0,0, 1,4'hA,1,1,0);
    add(1,1,1,0,0,0,0, 1,4'hA,1,1,0);
    add(1,1,1,0,0,0,1, 1,4'hA,0,1,0);
    add(1,0,0,0,0,1,0, 0,4'hA,0,1,0);
    add(1,0,0,0,0,1,1, 0,4'hA,0,0,0);
    // resync after 2 bits, then 0,1,1,0 -> 6
    add(1,1,1,1,0,1,0, 0,4'hA,1,0,0);
    add(1,1,1,0,0,1,0, 0,4'hA,1,0,0);
    add(1,1,0,1,0,1,0, 0,4'hA,1,0,1);
    add(1,1,1,0,0,1,0, 0,4'hA,1,0,1);
    add(1,1,1,0,0,1,0, 0,4'hA,1,0,1);
    add(1,1,0,0,0,1,0, 1,4'h6,0,0,1);
    // reset mid-word with a word buffered, stray non-first bit, then 3
    add(1,1,1,1,0,0,0, 1,4'h6,1,0,1);
    add(1,1,0,0,0,0,0, 1,4'h6,1,0,1);
    add(0,1,1,0,0,0,0, 0,4'h0,0,0,0);
    add(0,0,0,0,0,0,0, 0,4'h0,0,0,0);
    add(1,1,1,0,0,1,0, 0,4'h0,0,0,0);
    add(1,1,0,1,0,1,0, 0,4'h0,1,0,0);
    add(1,1,0,0,0,1,0, 0,4'h0,1,0,0);
    add(1,1,1,0,0,1,0, 0,4'h0,1,0,0);
    add(1,1,1,0,0,1,0, 1,4'h3,0,0,0);
    add(1,0,0,0,0,1,0, 0,4'h3,0,0,0);

    foreach (vq[i]) begin
      step(vq[i].rstn, vq[i].sv, vq[i].din, vq[i].sf, vq[i].lsb, vq[i].rdy, vq[i].clr);
      check($sformatf("vec%0d", i), vq[i].pv, vq[i].dout, vq[i].bsy, vq[i].ovr, vq[i].syn, 1'b0);
    end

    // completion in the same cycle the held word is accepted replaces it without overrun
    send_word(4'h9, 1'b0, 1'b0, 1'b0);
    check("hold9", 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'hC, 1'b1, 1'b0, 1'b1);
    check("b2bC", 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 && p_valid; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drainC", 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);

    // long stall between bits keeps the partial word
    begin
      logic stall_ok;
      stall_ok = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        if (busy !== 1'b1 || p_valid !== 1'b0) stall_ok = 1'b0;
      end
      n_vec++;
      if (!stall_ok) begin
        n_bad++;
        $display("FAIL stall: busy/p_valid changed during stall, want busy=1 p_valid=0");
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("stallA", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`else
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'hB, 1'b0, 1'b1, 1'b1);
    check("parwait", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("parok", 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("parok_drain", 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'h7, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("parbad", 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("parclr", 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("parsync", 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("parsync_word", 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
